// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl
// Triggered capture of the two ADC channels into a sample buffer write port.
// One input register stage (adc_q) feeds both the trigger detector and the
// buffer data path, so the trigger sample is exactly the first stored sample.
// Configuration is latched on arm and held for the whole capture sequence.

module adc_capture_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 12
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  arm,
  input  logic                  abort,
  input  logic                  sw_trig,
  input  logic [1:0]            trig_mode,
  input  logic [DATA_W-1:0]     trig_level,
  input  logic [7:0]            decim,
  input  logic [ADDR_W-1:0]     capture_len,
  input  logic [DATA_W-1:0]     adc_data_ch0,
  input  logic [DATA_W-1:0]     adc_data_ch1,
  output logic                  buf_wr,
  output logic [ADDR_W-1:0]     buf_addr,
  output logic [2*DATA_W-1:0]   buf_data,
  output logic                  armed,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ARMED   = 2'b01,
    ST_CAPTURE = 2'b10,
    ST_DONE    = 2'b11
  } state_t;

  localparam logic [1:0] MODE_IMM  = 2'b00;
  localparam logic [1:0] MODE_SW   = 2'b01;
  localparam logic [1:0] MODE_RISE = 2'b10;
  localparam logic [1:0] MODE_FALL = 2'b11;

  state_t                state_r;
  logic [2*DATA_W-1:0]   adc_q_r;
  logic [DATA_W-1:0]     prev_r;
  logic                  prev_valid_r;
  logic [1:0]            mode_r;
  logic [DATA_W-1:0]     level_r;
  logic [7:0]            decim_r;
  logic [ADDR_W-1:0]     len_r;
  logic [7:0]            decim_cnt_r;

  logic signed [DATA_W-1:0] cur_s;
  logic signed [DATA_W-1:0] prev_s;
  logic signed [DATA_W-1:0] level_s;
  logic                     trig_s;
  logic [ADDR_W-1:0]        next_addr_s;

  // Signed views of ch0, the previous ch0 sample and the latched threshold.
  assign cur_s       = adc_q_r[DATA_W-1:0];
  assign prev_s      = prev_r;
  assign level_s     = level_r;
  assign next_addr_s = buf_addr + {{(ADDR_W-1){1'b0}}, 1'b1};

  // Single input register stage for the sample pair {ch1, ch0}.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      adc_q_r <= {(2*DATA_W){1'b0}};
    end else begin
      adc_q_r <= {adc_data_ch1, adc_data_ch0};
    end
  end

  // Trigger condition for the latched mode; crossings need a valid previous sample.
  always_comb begin
    trig_s = 1'b0;
    case (mode_r)
      MODE_IMM:  trig_s = 1'b1;
      MODE_SW:   trig_s = sw_trig;
      MODE_RISE: trig_s = prev_valid_r && (prev_s <  level_s) && (cur_s >= level_s);
      MODE_FALL: trig_s = prev_valid_r && (prev_s >= level_s) && (cur_s <  level_s);
      default:   trig_s = 1'b0;
    endcase
  end

  // Capture sequencer: state, latched config, counters and all registered outputs.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      prev_r       <= {DATA_W{1'b0}};
      prev_valid_r <= 1'b0;
      mode_r       <= 2'b00;
      level_r      <= {DATA_W{1'b0}};
      decim_r      <= 8'd0;
      len_r        <= {ADDR_W{1'b0}};
      decim_cnt_r  <= 8'd0;
      buf_wr       <= 1'b0;
      buf_addr     <= {ADDR_W{1'b0}};
      buf_data     <= {(2*DATA_W){1'b0}};
      armed        <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else if (abort) begin
      // Abort wins over arm, trigger and the final write; buffer address/data hold.
      state_r      <= ST_IDLE;
      prev_valid_r <= 1'b0;
      decim_cnt_r  <= 8'd0;
      buf_wr       <= 1'b0;
      armed        <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      buf_wr <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (arm) begin
            mode_r       <= trig_mode;
            level_r      <= trig_level;
            decim_r      <= decim;
            len_r        <= capture_len;
            prev_valid_r <= 1'b0;
            done         <= 1'b0;
            state_r      <= ST_ARMED;
            armed        <= 1'b1;
            busy         <= 1'b1;
          end else begin
            armed <= 1'b0;
            busy  <= 1'b0;
          end
        end

        ST_ARMED: begin
          prev_r       <= adc_q_r[DATA_W-1:0];
          prev_valid_r <= 1'b1;
          if (trig_s) begin
            // The trigger sample itself is stored at address 0.
            buf_wr      <= 1'b1;
            buf_addr    <= {ADDR_W{1'b0}};
            buf_data    <= adc_q_r;
            decim_cnt_r <= 8'd0;
            armed       <= 1'b0;
            if (len_r == {ADDR_W{1'b0}}) begin
              state_r <= ST_DONE;
              done    <= 1'b1;
              busy    <= 1'b0;
            end else begin
              state_r <= ST_CAPTURE;
              busy    <= 1'b1;
            end
          end else begin
            armed <= 1'b1;
            busy  <= 1'b1;
          end
        end

        ST_CAPTURE: begin
          armed <= 1'b0;
          if (decim_cnt_r == decim_r) begin
            // One stored sample every decim+1 cycles; stop at the last address.
            decim_cnt_r <= 8'd0;
            buf_wr      <= 1'b1;
            buf_addr    <= next_addr_s;
            buf_data    <= adc_q_r;
            if (next_addr_s == len_r) begin
              state_r <= ST_DONE;
              done    <= 1'b1;
              busy    <= 1'b0;
            end else begin
              busy <= 1'b1;
            end
          end else begin
            decim_cnt_r <= decim_cnt_r + 8'd1;
            busy        <= 1'b1;
          end
        end

        default: begin
          state_r <= ST_IDLE;
          armed   <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb_adc_capture_ctrl
// Table of capture scenarios (trigger mode, config, sample waveform and the
// hand-derived trigger sample index) plus hand-written reset sequences.
// Expected buffer writes are pushed to a scoreboard queue before each run and
// popped as the DUT writes; status outputs are checked after every edge.

module tb_adc_capture_ctrl;

  localparam int BIG = 1000000;

  logic        sys_clk = 1'b0;
  logic        rst = 1'b0;
  logic        arm = 1'b0;
  logic        abort = 1'b0;
  logic        sw_trig = 1'b0;
  logic [1:0]  trig_mode = 2'b00;
  logic [11:0] trig_level = 12'd0;
  logic [7:0]  decim = 8'd0;
  logic [9:0]  capture_len = 10'd0;
  logic [11:0] adc_data_ch0 = 12'd0;
  logic [11:0] adc_data_ch1 = 12'd0;
  logic        buf_wr;
  logic [9:0]  buf_addr;
  logic [23:0] buf_data;
  logic        armed;
  logic        busy;
  logic        done;

  adc_capture_ctrl #(.ADDR_W(10), .DATA_W(12)) dut (
    .sys_clk      (sys_clk),
    .rst          (rst),
    .arm          (arm),
    .abort        (abort),
    .sw_trig      (sw_trig),
    .trig_mode    (trig_mode),
    .trig_level   (trig_level),
    .decim        (decim),
    .capture_len  (capture_len),
    .adc_data_ch0 (adc_data_ch0),
    .adc_data_ch1 (adc_data_ch1),
    .buf_wr       (buf_wr),
    .buf_addr     (buf_addr),
    .buf_data     (buf_data),
    .armed        (armed),
    .busy         (busy),
    .done         (done)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [1:0] mode;
    int lvl;
    int dec;
    int len;
    int start;
    int step;
    int peak;
    int sw_slot;
    int rearm_slot;
    int abort_slot;
    int exp_k;      // slot index of the trigger sample, -1 if none
  } vec_t;

  typedef struct {
    int          edge_n;
    int          addr;
    logic [23:0] data;
  } wr_t;

  wr_t  sbq[$];
  vec_t vt[11];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cur_id = -1;
  int   cur_edge = -1;

  function automatic vec_t mk(logic [1:0] mode, int lvl, int dec, int len, int start,
                              int step, int peak, int sw, int rearm, int ab, int k);
    vec_t v;
    v.mode = mode; v.lvl = lvl; v.dec = dec; v.len = len; v.start = start;
    v.step = step; v.peak = peak; v.sw_slot = sw; v.rearm_slot = rearm;
    v.abort_slot = ab; v.exp_k = k;
    return v;
  endfunction

  // ch0 waveform: ramp up to 'peak', then ramp back down at the same rate.
  function automatic int samp(vec_t v, int i);
    if (i <= v.peak) return v.start + v.step * i;
    return v.start + v.step * v.peak - v.step * (i - v.peak);
  endfunction

  function automatic logic [23:0] pair(vec_t v, int i);
    int c0;
    logic [11:0] a;
    logic [11:0] b;
    c0 = samp(v, i);
    a = c0[11:0];
    b = a + 12'h555;
    return {b, a};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (vec %0d, edge %0d): got 0x%0h, expected 0x%0h",
               nm, cur_id, cur_edge, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int d, fin, k1, last, t, e, lv;
    logic [23:0] p;
    wr_t w;
    cur_id = id;
    d = v.dec + 1;
    fin = (v.exp_k >= 0) ? v.exp_k + 1 + v.len * d : BIG;
    k1  = (v.exp_k >= 0) ? v.exp_k + 1 : BIG;
    sbq.delete();
    if (v.exp_k >= 0) begin
      for (int m = 0; m <= v.len; m++) begin
        e = v.exp_k + 1 + m * d;
        if (e < v.abort_slot) begin
          w.edge_n = e; w.addr = m; w.data = pair(v, v.exp_k + m * d);
          sbq.push_back(w);
        end
      end
    end
    last = (fin < v.abort_slot) ? fin : 0;
    if (v.abort_slot < BIG && v.abort_slot > last) last = v.abort_slot;
    t = last + 3;
    lv = v.lvl;
    for (int i = 0; i <= t; i++) begin
      @(negedge sys_clk);
      p = pair(v, i);
      adc_data_ch0 = p[11:0];
      adc_data_ch1 = p[23:12];
      arm     = (i == 0) || (i == v.rearm_slot);
      abort   = (i == v.abort_slot);
      sw_trig = (i == v.sw_slot);
      if (i == 0) begin
        trig_mode   = v.mode;
        trig_level  = lv[11:0];
        decim       = v.dec[7:0];
        capture_len = v.len[9:0];
      end else begin
        // Config is only meaningful at arm; drive misleading values elsewhere.
        trig_mode   = ~v.mode;
        trig_level  = lv[11:0] ^ 12'hfff;
        decim       = v.dec[7:0] ^ 8'h05;
        capture_len = (v.len == 0) ? 10'd5 : 10'd0;
      end
      @(posedge sys_clk);
      #1;
      cur_edge = i;
      if (buf_wr) begin
        if (sbq.size() == 0) begin
          chk("unexpected_wr", {31'd0, buf_wr}, 32'd0);
        end else begin
          w = sbq.pop_front();
          chk("wr_edge", i, w.edge_n);
          chk("wr_addr", {22'd0, buf_addr}, w.addr);
          chk("wr_data", {8'd0, buf_data}, {8'd0, w.data});
        end
      end else if (sbq.size() > 0 && sbq[0].edge_n == i) begin
        chk("missing_wr", {31'd0, buf_wr}, 32'd1);
        void'(sbq.pop_front());
      end
      chk("armed", {31'd0, armed}, (i < k1 && i < v.abort_slot) ? 32'd1 : 32'd0);
      chk("busy",  {31'd0, busy},  (i < fin && i < v.abort_slot) ? 32'd1 : 32'd0);
      chk("done",  {31'd0, done},  (i >= fin && i < v.abort_slot) ? 32'd1 : 32'd0);
    end
    arm = 1'b0; abort = 1'b0; sw_trig = 1'b0;
    chk("sb_empty", sbq.size(), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_buf_wr"},   {31'd0, buf_wr}, 32'd0);
    chk({tag, "_buf_addr"}, {22'd0, buf_addr}, 32'd0);
    chk({tag, "_buf_data"}, {8'd0, buf_data}, 32'd0);
    chk({tag, "_armed"},    {31'd0, armed}, 32'd0);
    chk({tag, "_busy"},     {31'd0, busy}, 32'd0);
    chk({tag, "_done"},     {31'd0, done}, 32'd0);
  endtask

  initial begin
    //           mode   lvl  dec len start step peak sw  rearm abort k
    vt[0]  = mk(2'b00,    0,   0,  3,  10,  1, BIG, -1, -1, BIG,  0); // immediate, back-to-back
    vt[1]  = mk(2'b00,    0,   2,  2, 200,  3, BIG, -1, -1, BIG,  0); // decimated by 3
    vt[2]  = mk(2'b10,  100,   0,  1,  90,  1, BIG, -1, -1, BIG, 10); // rising through 100
    vt[3]  = mk(2'b11,    0,   1,  2,  -5,  2,   6, -1, -1, BIG, 10); // falling through 0
    vt[4]  = mk(2'b01,    0,   0,  0,   0,  7, BIG,  5, -1, BIG,  4); // software trigger
    vt[5]  = mk(2'b10,  -50,   0,  1, -60,  5, BIG, -1, -1, BIG,  2); // negative threshold
    vt[6]  = mk(2'b10,  100,   0,  1, 100,  1, BIG, -1, -1,  20, -1); // starts at level: no crossing
    vt[7]  = mk(2'b00,    0, 255,  1,  50,  1, BIG, -1, -1, BIG,  0); // maximum decimation
    vt[8]  = mk(2'b00,    0,   0, 15, 300,  2, BIG, -1,  3,   7,  0); // rearm ignored, abort after addr 5
    vt[9]  = mk(2'b00,    0,   0,  0, 400,  1, BIG, -1, -1,   4,  0); // abort clears done
    vt[10] = mk(2'b00,    0,   0,  0, 777,  0, BIG, -1, -1, BIG,  0); // single write after reset

    // Power-on reset.
    #2 rst = 1'b1;
    #1 chk_all_zero("reset");
    repeat (3) @(negedge sys_clk);
    rst = 1'b0;
    @(posedge sys_clk); #1;
    chk_all_zero("idle");

    for (int n = 0; n < 10; n++) run_vec(vt[n], n);

    // Reset asserted in the middle of a capture clears outputs immediately.
    cur_id = 100;
    @(negedge sys_clk);
    trig_mode = 2'b00; trig_level = 12'd0; decim = 8'd0; capture_len = 10'd15;
    adc_data_ch0 = 12'h123; adc_data_ch1 = 12'h456;
    arm = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    arm = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("pre_rst_wr",   {31'd0, buf_wr}, 32'd1);
    chk("pre_rst_addr", {22'd0, buf_addr}, 32'd2);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    #1 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    @(negedge sys_clk);
    rst = 1'b0;

    run_vec(vt[10], 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
